// File: rtl/mpi_header_parser.sv
// mpi_header_parser
// Receive-side stage for the 64-bit MPI packet stream. Each packet is four
// header flits followed by zero or more payload flits.
//   - The four header flits are parsed into registered hdr_* fields.
//     hdr_valid/hdr_ready hand the parsed header over.
//   - The payload is passed straight through to m_axis with no added latency.
//   - The byte count of the payload is compared with the declared size.
// Ports:
//   clk, aresetn             clock, asynchronous active-low reset
//   s_axis_*                 network-side input stream
//   hdr_* / hdr_valid/ready  parsed header and its handshake
//   m_axis_*                 payload output stream
//   len_err, short_err       one-cycle error pulses
//   len_err_cnt, short_err_cnt  saturating error counters
module mpi_header_parser #(
  parameter int CNT_W     = 16,
  parameter bit LEN_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [15:0]      hdr_dst_rank,
  output logic [7:0]       hdr_src_rank,
  output logic [7:0]       hdr_packet_type,
  output logic [31:0]      hdr_size,
  output logic [7:0]       hdr_tag,
  output logic [47:0]      hdr_mac_dst,
  output logic [47:0]      hdr_mac_src,
  output logic [31:0]      hdr_ip_dst,
  output logic [31:0]      hdr_ip_src,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             len_err,
  output logic             short_err,
  output logic [CNT_W-1:0] len_err_cnt,
  output logic [CNT_W-1:0] short_err_cnt
);

  typedef enum logic [2:0] {S_H0, S_H1, S_H2, S_H3, S_HWAIT, S_PAY} state_t;

  state_t             state_q;
  logic               pay_done_q;     // header-only packet: skip PAY
  logic [31:0]        byte_cnt_q;
  logic [15:0]        dst_rank_q;
  logic [7:0]         src_rank_q;
  logic [7:0]         packet_type_q;
  logic [31:0]        size_q;
  logic [7:0]         tag_q;
  logic [47:0]        mac_dst_q;
  logic [47:0]        mac_src_q;
  logic [31:0]        ip_dst_q;
  logic [31:0]        ip_src_q;
  logic               hdr_valid_q;
  logic               len_err_q;
  logic               short_err_q;
  logic [CNT_W-1:0]   len_err_cnt_q;
  logic [CNT_W-1:0]   short_err_cnt_q;

  logic               in_hdr;
  logic               in_pay;
  logic               beat;
  logic [3:0]         keep_cnt;
  logic [31:0]        pay_sum;
  logic               len_fire;
  logic               short_fire;

  assign in_hdr = (state_q == S_H0) || (state_q == S_H1) ||
                  (state_q == S_H2) || (state_q == S_H3);
  assign in_pay = (state_q == S_PAY);

  // Header flits are always accepted; payload follows downstream backpressure.
  assign s_axis_tready = in_hdr | (in_pay & m_axis_tready);
  assign beat          = s_axis_tvalid & s_axis_tready;

  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = in_pay & s_axis_tvalid;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      keep_cnt = keep_cnt + {3'b000, s_axis_tkeep[i]};
    end
  end

  // Running total including the current beat; wraps modulo 2^32.
  assign pay_sum = byte_cnt_q + {28'd0, keep_cnt};

  always_comb begin
    short_fire = beat & s_axis_tlast &
                 ((state_q == S_H0) || (state_q == S_H1) || (state_q == S_H2));
    len_fire   = 1'b0;
    if (LEN_CHECK) begin
      // Header-only packets are checked against zero received bytes.
      if ((state_q == S_HWAIT) && hdr_ready && pay_done_q && (size_q != 32'd0))
        len_fire = 1'b1;
      if (in_pay && beat && s_axis_tlast && (pay_sum != size_q))
        len_fire = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= S_H0;
      pay_done_q      <= 1'b0;
      byte_cnt_q      <= '0;
      dst_rank_q      <= '0;
      src_rank_q      <= '0;
      packet_type_q   <= '0;
      size_q          <= '0;
      tag_q           <= '0;
      mac_dst_q       <= '0;
      mac_src_q       <= '0;
      ip_dst_q        <= '0;
      ip_src_q        <= '0;
      hdr_valid_q     <= 1'b0;
      len_err_q       <= 1'b0;
      short_err_q     <= 1'b0;
      len_err_cnt_q   <= '0;
      short_err_cnt_q <= '0;
    end else begin
      len_err_q   <= len_fire;
      short_err_q <= short_fire;
      if (len_fire && (len_err_cnt_q != {CNT_W{1'b1}}))
        len_err_cnt_q <= len_err_cnt_q + 1'b1;
      if (short_fire && (short_err_cnt_q != {CNT_W{1'b1}}))
        short_err_cnt_q <= short_err_cnt_q + 1'b1;

      case (state_q)
        S_H0: if (beat) begin
          dst_rank_q    <= s_axis_tdata[15:0];
          src_rank_q    <= s_axis_tdata[23:16];
          packet_type_q <= s_axis_tdata[31:24];
          size_q        <= s_axis_tdata[63:32];
          state_q       <= s_axis_tlast ? S_H0 : S_H1;
        end
        S_H1: if (beat) begin
          mac_dst_q <= s_axis_tdata[47:0];
          tag_q     <= s_axis_tdata[55:48];
          state_q   <= s_axis_tlast ? S_H0 : S_H2;
        end
        S_H2: if (beat) begin
          mac_src_q <= s_axis_tdata[47:0];
          state_q   <= s_axis_tlast ? S_H0 : S_H3;
        end
        S_H3: if (beat) begin
          ip_dst_q    <= s_axis_tdata[31:0];
          ip_src_q    <= s_axis_tdata[63:32];
          pay_done_q  <= s_axis_tlast;
          hdr_valid_q <= 1'b1;
          state_q     <= S_HWAIT;
        end
        S_HWAIT: if (hdr_ready) begin
          hdr_valid_q <= 1'b0;
          byte_cnt_q  <= '0;
          state_q     <= pay_done_q ? S_H0 : S_PAY;
        end
        S_PAY: if (beat) begin
          byte_cnt_q <= pay_sum;
          if (s_axis_tlast) state_q <= S_H0;
        end
        default: state_q <= S_H0;
      endcase
    end
  end

  assign hdr_dst_rank    = dst_rank_q;
  assign hdr_src_rank    = src_rank_q;
  assign hdr_packet_type = packet_type_q;
  assign hdr_size        = size_q;
  assign hdr_tag         = tag_q;
  assign hdr_mac_dst     = mac_dst_q;
  assign hdr_mac_src     = mac_src_q;
  assign hdr_ip_dst      = ip_dst_q;
  assign hdr_ip_src      = ip_src_q;
  assign hdr_valid       = hdr_valid_q;
  assign len_err         = len_err_q;
  assign short_err       = short_err_q;
  assign len_err_cnt     = len_err_cnt_q;
  assign short_err_cnt   = short_err_cnt_q;

endmodule
